// File: rtl/range_reader.sv
// -----------------------------------------------------------------------------
// range_reader
//
// Host-side sequencer for the Collatz range block. An accepted req launches
// one batch on the range block (rgo pulse with rstart = base), waits for its
// done pulse, then reads back all RAM_WORDS iteration counts through the
// range block's read port (rstart used as the read address, rcount returned
// one cycle later). Each result is presented on a valid/ready interface,
// tagged with its starting number. The batch maximum and its argmax are
// tracked as results are accepted.
//
// Ports
//   clk        in   1   clock
//   reset      in   1   synchronous reset, active-high
//   req        in   1   start a batch (only honoured while idle)
//   base       in   32  first starting number, latched on accepted req
//   busy       out  1   high whenever a batch is in progress
//   rgo        out  1   go strobe to the range block
//   rstart     out  32  launch value / read address to the range block
//   rdone      in   1   done pulse from the range block
//   rcount     in   16  registered RAM read data from the range block
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   out_n      out  32  starting number of the result (base + idx, wraps)
//   out_count  out  16  iteration count for out_n
//   out_last   out  1   marks the final result of the batch
//   max_count  out  16  largest count accepted so far in this batch
//   max_n      out  32  starting number of max_count (earliest on ties)
//   batch_done out  1   one-cycle pulse after the final handshake
//   err        out  1   sticky timeout flag, cleared by next accepted req
// -----------------------------------------------------------------------------
module range_reader #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4,
    parameter int TIMEOUT       = 1048576
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] base,
    output logic        busy,
    output logic        rgo,
    output logic [31:0] rstart,
    input  logic        rdone,
    input  logic [15:0] rcount,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_n,
    output logic [15:0] out_count,
    output logic        out_last,
    output logic [15:0] max_count,
    output logic [31:0] max_n,
    output logic        batch_done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_ADDR   = 3'd3,
        S_CAPT   = 3'd4,
        S_OUT    = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;

    logic [31:0]              r_base;
    logic [RAM_ADDR_BITS-1:0] r_idx;
    logic [TW-1:0]            r_timer;

    logic                     r_out_valid;
    logic [31:0]              r_out_n;
    logic [15:0]              r_out_count;
    logic                     r_out_last;
    logic [15:0]              r_max_count;
    logic [31:0]              r_max_n;
    logic                     r_batch_done;
    logic                     r_err;

    logic                     w_hs;
    logic                     w_timeout;
    logic                     w_last_idx;

    assign w_hs       = r_out_valid && out_ready;
    // WAIT lasts TIMEOUT cycles: timer values 0 .. TIMEOUT-1.
    assign w_timeout  = (r_timer == TW'(TIMEOUT - 1));
    assign w_last_idx = (r_idx == RAM_ADDR_BITS'(RAM_WORDS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req) w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                // rdone takes priority over a coincident timeout
                if (rdone) begin
                    w_next = S_ADDR;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_ADDR:   w_next = S_CAPT;
            S_CAPT:   w_next = S_OUT;
            S_OUT: begin
                if (w_hs) begin
                    w_next = r_out_last ? S_IDLE : S_ADDR;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Output logic (combinational from state, base and index)
    always_comb begin
        busy   = (r_state != S_IDLE);
        rgo    = (r_state == S_LAUNCH);
        rstart = 32'd0;
        case (r_state)
            S_LAUNCH, S_WAIT: rstart = r_base;
            S_ADDR:           rstart = 32'(r_idx);
            default:          rstart = 32'd0;
        endcase
    end

    // Batch bookkeeping, result register and max tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base       <= 32'd0;
            r_idx        <= '0;
            r_timer      <= '0;
            r_out_valid  <= 1'b0;
            r_out_n      <= 32'd0;
            r_out_count  <= 16'd0;
            r_out_last   <= 1'b0;
            r_max_count  <= 16'd0;
            r_max_n      <= 32'd0;
            r_batch_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_batch_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_base      <= base;
                        r_max_count <= 16'd0;
                        r_max_n     <= base;
                        r_err       <= 1'b0;
                        r_idx       <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (!rdone) begin
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                end
                S_CAPT: begin
                    // rcount now holds mem[idx], registered on the ADDR edge
                    r_out_count <= rcount;
                    r_out_n     <= r_base + 32'(r_idx);
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_last_idx;
                end
                S_OUT: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        // strict compare keeps the earliest n on ties
                        if (r_out_count > r_max_count) begin
                            r_max_count <= r_out_count;
                            r_max_n     <= r_out_n;
                        end
                        if (r_out_last) begin
                            r_batch_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_n      = r_out_n;
    assign out_count  = r_out_count;
    assign out_last   = r_out_last;
    assign max_count  = r_max_count;
    assign max_n      = r_max_n;
    assign batch_done = r_batch_done;
    assign err        = r_err;

endmodule

// File: tb/tb_range_reader.sv
module tb_range_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] base;
    logic        busy;
    logic        rgo;
    logic [31:0] rstart;
    logic        rdone;
    logic [15:0] rcount;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_n;
    logic [15:0] out_count;
    logic        out_last;
    logic [15:0] max_count;
    logic [31:0] max_n;
    logic        batch_done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;

    range_reader #(
        .RAM_WORDS(16),
        .RAM_ADDR_BITS(4),
        .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .base(base), .busy(busy),
        .rgo(rgo), .rstart(rstart), .rdone(rdone), .rcount(rcount),
        .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n),
        .out_count(out_count), .out_last(out_last), .max_count(max_count),
        .max_n(max_n), .batch_done(batch_done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the range block: done arrives rb_lat cycles
    // after go is sampled; reads return mem[addr] one cycle later.
    logic [15:0] mem [16];
    int          rb_lat = 5;
    bit          rb_en = 1'b1;
    int          rb_cnt = 0;
    logic        rb_done = 1'b0;
    logic        stray_done = 1'b0;
    int          rgo_cnt = 0;

    assign rdone = rb_done | stray_done;

    always @(posedge clk) begin
        rcount  <= mem[rstart[3:0]];
        rb_done <= 1'b0;
        if (rb_cnt > 0) begin
            if (rb_cnt == 1 && rb_en) rb_done <= 1'b1;
            rb_cnt <= rb_cnt - 1;
        end else if (rgo === 1'b1) begin
            rb_cnt <= rb_lat;
        end
        if (rgo === 1'b1) rgo_cnt <= rgo_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] collatz(input longint unsigned n);
        int steps = 0;
        while (n != 1) begin
            n = n[0] ? (3 * n + 1) : (n >> 1);
            steps++;
        end
        return 16'(steps);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctrl"}, 64'({busy, rgo, out_valid, out_last, batch_done, err}), 64'(0));
        chk({tag, "_rstart"}, 64'(rstart), 64'(0));
        chk({tag, "_out_n"}, 64'(out_n), 64'(0));
        chk({tag, "_counts"}, 64'({out_count, max_count}), 64'(0));
        chk({tag, "_max_n"}, 64'(max_n), 64'(0));
    endtask

    task automatic wait_rb_idle();
        for (int i = 0; i < 500 && rb_cnt != 0; i++) @(negedge clk);
    endtask

    // Runs one batch and checks every result against a model built from
    // mem[] and the base. rst_at >= 0 asserts reset when that result shows.
    task automatic run_batch(input logic [31:0] b, input int stall, input bit rnd,
                             input bit inj, input int rst_at);
        logic [31:0] en [16];
        logic [15:0] ec [16];
        logic [15:0] mc = 16'd0;
        logic [31:0] mn = b;
        logic [31:0] pn = 32'd0;
        logic [15:0] pc = 16'd0;
        int k = 0, gap = 0, need = 0, wcnt = 0, rgo0;
        bit seen = 0, done_seen = 0, pv = 0, pr = 0, pl = 0, hs_prev = 0;
        for (int i = 0; i < 16; i++) begin
            en[i] = b + 32'(i);
            ec[i] = mem[i];
            if (ec[i] > mc) begin
                mc = ec[i];
                mn = en[i];
            end
        end
        wait_rb_idle();
        @(negedge clk);
        rgo0 = rgo_cnt;
        base = b;
        req  = 1'b1;
        @(negedge clk);
        req  = 1'b0;
        base = $urandom;
        chk("launch_flags", 64'({busy, rgo, err, out_valid}), 64'(4'b1100));
        chk("launch_rstart", 64'(rstart), 64'(b));
        @(negedge clk);
        chk("wait_rgo_rstart", 64'({rgo, rstart}), 64'({1'b0, b}));
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            if (cyc > 0) @(negedge clk);
            gap++;
            if (pv && !pr)
                chk("stall_hold", 64'({out_valid, out_n, out_count, out_last}),
                    64'({1'b1, pn, pc, pl}));
            chk("batch_done", 64'(batch_done), 64'(hs_prev && pl));
            if (hs_prev && pl) done_seen = 1;
            if (out_valid && !seen) begin
                chk("out_n", 64'(out_n), 64'(en[k]));
                chk("out_count", 64'(out_count), 64'(ec[k]));
                chk("out_last", 64'(out_last), 64'(k == 15));
                if (stall == 0 && k > 0) chk("spacing", 64'(gap), 64'(3));
                gap  = 0;
                seen = 1;
                need = rnd ? int'($urandom_range(0, stall)) : stall;
                wcnt = 0;
                if (k == rst_at) begin
                    reset = 1'b1;
                    @(negedge clk);
                    check_reset_vals("midreset");
                    reset = 1'b0;
                    return;
                end
            end
            if (out_valid) begin
                out_ready = (wcnt >= need);
                wcnt++;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            hs_prev = out_valid && out_ready;
            if (hs_prev) begin
                k++;
                seen = 0;
            end
            pv = out_valid; pr = out_ready; pn = out_n; pc = out_count; pl = out_last;
            if (inj) begin
                req  = !done_seen && !(out_valid && out_last) && 1'($urandom_range(0, 1));
                base = $urandom;
            end
        end
        req = 1'b0;
        out_ready = 1'b0;
        chk("batch_finished", 64'(done_seen), 64'(1));
        chk("n_results", 64'(k), 64'(16));
        chk("max_count", 64'(max_count), 64'(mc));
        chk("max_n", 64'(max_n), 64'(mn));
        chk("rgo_pulses", 64'(rgo_cnt - rgo0), 64'(1));
        chk("end_flags", 64'({busy, err, out_valid}), 64'(0));
    endtask

    task automatic run_timeout(input logic [31:0] b);
        int  wc = 0;
        bit  vs = 0;
        wait_rb_idle();
        @(negedge clk);
        base = b;
        req  = 1'b1;
        @(negedge clk);
        req  = 1'b0;
        chk("to_launch", 64'({busy, rgo}), 64'(2'b11));
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            wc++;
            if (out_valid) vs = 1;
        end
        chk("timeout_len", 64'(wc), 64'(64));
        chk("timeout_flags", 64'({busy, err, out_valid, vs}), 64'(4'b0100));
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'({busy, err}), 64'(2'b01));
    endtask

    initial begin
        logic [15:0] t1 [16];
        t1 = '{16'd0, 16'd1, 16'd7, 16'd2, 16'd5, 16'd8, 16'd16, 16'd3,
               16'd19, 16'd6, 16'd14, 16'd9, 16'd9, 16'd17, 16'd17, 16'd4};
        reset = 1'b1; req = 1'b0; base = 32'd0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // rdone and out_ready while idle have no effect
        @(negedge clk);
        stray_done = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        stray_done = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("idle_stray", 64'({busy, out_valid, err}), 64'(0));

        // Known counts for n = 1..16
        for (int i = 0; i < 16; i++) mem[i] = t1[i];
        rb_lat = 7;
        run_batch(32'd1, 0, 0, 0, -1);
        chk("t1_max", 64'({max_count, max_n}), 64'({16'd19, 32'd9}));

        // Fixed backpressure of 5 cycles per result
        run_batch(32'd1, 5, 0, 0, -1);

        // Collatz counts for base 12, then an explicit tie at the running max
        for (int i = 0; i < 16; i++) mem[i] = collatz(64'(12 + i));
        run_batch(32'd12, 0, 0, 0, -1);
        mem[0] = 16'd17; mem[1] = 16'd17;
        for (int i = 2; i < 16; i++) mem[i] = 16'($urandom_range(0, 16));
        run_batch(32'd14, 1, 1, 0, -1);
        chk("tie_max_n", 64'({max_count, max_n}), 64'({16'd17, 32'd14}));

        // req pulses while busy are ignored
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        rb_lat = 12;
        run_batch($urandom, 2, 1, 1, -1);

        // Timeout, then rdone coincident with the last WAIT cycle, then late rdone
        rb_en = 1'b0;
        run_timeout(32'h55);
        rb_en  = 1'b1;
        rb_lat = 63;
        run_batch(32'd100, 0, 0, 0, -1);
        rb_lat = 64;
        run_timeout(32'h77);
        rb_lat = 9;
        run_batch(32'd7, 0, 0, 0, -1);

        // Reset while the idx==7 result is pending, then a clean batch
        run_batch(32'd300, 3, 0, 0, 7);
        repeat (10) @(negedge clk);
        check_reset_vals("post_reset");
        run_batch(32'd301, 0, 0, 0, -1);

        // Randomised batches, including a base that wraps past 2^32
        for (int r = 0; r < 6; r++) begin
            logic [31:0] b;
            b = (r == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
            mem[$urandom_range(0, 15)] = mem[$urandom_range(0, 15)];
            rb_lat = $urandom_range(1, 50);
            run_batch(b, 3, 1, 1'(r % 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
